// File: rtl/perf_window_if.sv
// Bus bundle between the window controller and its environment:
// command inputs, pipeline monitor inputs, counter datapath control and read port.
interface perf_window_if #(
    parameter int CNT_W = 32
);
    logic             arm_i;
    logic             abort_i;
    logic [CNT_W-1:0] timeout_i;
    logic             valid_signal;
    logic [31:0]      inst;
    logic [CNT_W-1:0] high_count_i;
    logic [CNT_W-1:0] low_count_i;
    logic             cnt_clr_o;
    logic             cnt_hi_en_o;
    logic             cnt_lo_en_o;
    logic             busy_o;
    logic             done_o;
    logic [2:0]       state_o;
    logic [1:0]       rd_addr_i;
    logic [CNT_W-1:0] rd_data_o;

    // Environment side: drives commands, pipeline status and counter values.
    modport master (
        output arm_i, abort_i, timeout_i, valid_signal, inst,
               high_count_i, low_count_i, rd_addr_i,
        input  cnt_clr_o, cnt_hi_en_o, cnt_lo_en_o, busy_o, done_o,
               state_o, rd_data_o
    );

    // Controller side.
    modport slave (
        input  arm_i, abort_i, timeout_i, valid_signal, inst,
               high_count_i, low_count_i, rd_addr_i,
        output cnt_clr_o, cnt_hi_en_o, cnt_lo_en_o, busy_o, done_o,
               state_o, rd_data_o
    );
endinterface

// File: rtl/perf_window_ctrl.sv
// Measurement-window controller for the valid/bubble cycle counters.
// Arms on command, opens on the first valid cycle, closes on halt, timeout
// or abort, snapshots the counters and serves them on a registered read port.
module perf_window_ctrl #(
    parameter logic [31:0] HALT_INST = 32'h000000EF,
    parameter int          CNT_W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    perf_window_if.slave bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLEAR    = 3'd1;
    localparam logic [2:0] S_ARMED    = 3'd2;
    localparam logic [2:0] S_COUNTING = 3'd3;
    localparam logic [2:0] S_SNAP     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] elapsed, el_inc;
    logic [CNT_W-1:0] snap_hi, snap_lo, snap_el;
    logic [CNT_W-1:0] rd_q;
    logic             halted, timed_out, aborted, done_flag, done_q;
    logic             is_halt, abort_act, tmo_hit, hi_en, lo_en;

    assign is_halt   = (bus.inst == HALT_INST);
    assign abort_act = bus.abort_i && (state != S_IDLE);
    assign el_inc    = elapsed + ONE;
    // Timeout compares the count as it will be after this cycle, so the
    // ARMED start cycle is included in the total.
    assign tmo_hit   = (bus.timeout_i != '0) && (el_inc == bus.timeout_i);

    // Counter enables: only while the window is open and not closing this cycle.
    always_comb begin
        hi_en = 1'b0;
        lo_en = 1'b0;
        if (!rst && !abort_act && !is_halt) begin
            case (state)
                S_ARMED:    hi_en = bus.valid_signal;
                S_COUNTING: begin
                    hi_en = bus.valid_signal;
                    lo_en = ~bus.valid_signal;
                end
                default: ;
            endcase
        end
    end

    // Next-state selection; abort overrides every other event.
    always_comb begin
        state_nxt = state;
        if (abort_act) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (bus.arm_i) state_nxt = S_CLEAR;
                S_CLEAR:        state_nxt = S_ARMED;
                S_ARMED: begin
                    if (is_halt)                state_nxt = S_SNAP;
                    else if (bus.valid_signal)  state_nxt = S_COUNTING;
                end
                S_COUNTING: begin
                    if (is_halt || tmo_hit)     state_nxt = S_SNAP;
                end
                S_SNAP:         state_nxt = S_DONE;
                default:        state_nxt = S_IDLE;
            endcase
        end
    end

    // State, elapsed count, status flags and snapshots.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            elapsed   <= '0;
            snap_hi   <= '0;
            snap_lo   <= '0;
            snap_el   <= '0;
            halted    <= 1'b0;
            timed_out <= 1'b0;
            aborted   <= 1'b0;
            done_flag <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            if (abort_act) begin
                aborted <= 1'b1;
            end else begin
                case (state)
                    S_CLEAR: begin
                        elapsed   <= '0;
                        halted    <= 1'b0;
                        timed_out <= 1'b0;
                        aborted   <= 1'b0;
                        done_flag <= 1'b0;
                    end
                    S_ARMED: begin
                        if (is_halt)               halted  <= 1'b1;
                        else if (bus.valid_signal) elapsed <= ONE;
                    end
                    S_COUNTING: begin
                        if (is_halt) begin
                            halted <= 1'b1;
                        end else begin
                            if (elapsed != '1) elapsed <= el_inc;
                            if (tmo_hit)       timed_out <= 1'b1;
                        end
                    end
                    S_SNAP: begin
                        snap_hi   <= bus.high_count_i;
                        snap_lo   <= bus.low_count_i;
                        snap_el   <= elapsed;
                        done_flag <= 1'b1;
                        done_q    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered snapshot read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            case (bus.rd_addr_i)
                2'd0:    rd_q <= snap_hi;
                2'd1:    rd_q <= snap_lo;
                2'd2:    rd_q <= snap_el;
                default: rd_q <= {{(CNT_W-4){1'b0}}, aborted, timed_out, halted, done_flag};
            endcase
        end
    end

    assign bus.cnt_clr_o   = (state == S_CLEAR);
    assign bus.cnt_hi_en_o = hi_en;
    assign bus.cnt_lo_en_o = lo_en;
    assign bus.busy_o      = (state == S_CLEAR) || (state == S_ARMED) ||
                             (state == S_COUNTING) || (state == S_SNAP);
    assign bus.done_o      = done_q;
    assign bus.state_o     = state;
    assign bus.rd_data_o   = rd_q;
endmodule
